// File: rtl/nor_gate_1bit.sv
// Single-bit NOR leaf gate with a clocked observation stage:
// registered output, edge pulses and a saturating transition count.
module nor_gate_1bit #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    output logic             c,
    output logic             c_q,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             c_d;
    logic             rise_d, rise_q;
    logic             fall_d, fall_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign c = ~(a | b);

    // c_q doubles as the previous-sample register for edge detection
    always_comb begin
        c_d    = c;
        rise_d = c & ~c_q;
        fall_d = ~c & c_q;
        cnt_d  = cnt_q;
        if ((c != c_q) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            c_q    <= c_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rise       = rise_q;
    assign fall       = fall_q;
    assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_nor_gate_1bit.sv
// Randomized self-checking bench for nor_gate_1bit, run at the default
// counter width and at CNT_W=2 to exercise saturation.
module tb_nor_gate_1bit;

    logic       clk;
    logic       rst;
    logic       a, b;
    logic       c8, cq8, rise8, fall8;
    logic [7:0] cnt8;
    logic       c2, cq2, rise2, fall2;
    logic [1:0] cnt2;

    int n_chk;
    int n_err;

    // reference model state
    bit m_cq, m_rise, m_fall;
    int m_cnt8, m_cnt2;

    nor_gate_1bit #(.CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .a(a), .b(b),
        .c(c8), .c_q(cq8), .rise(rise8), .fall(fall8),
        .toggle_cnt(cnt8)
    );

    nor_gate_1bit #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .a(a), .b(b),
        .c(c2), .c_q(cq2), .rise(rise2), .fall(fall2),
        .toggle_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cq   = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_cnt8 = 0;
        m_cnt2 = 0;
    endtask

    task automatic check_regs();
        chk("cq8",   32'(cq8),   32'(m_cq));
        chk("rise8", 32'(rise8), 32'(m_rise));
        chk("fall8", 32'(fall8), 32'(m_fall));
        chk("cnt8",  32'(cnt8),  32'(m_cnt8));
        chk("cq2",   32'(cq2),   32'(m_cq));
        chk("rise2", 32'(rise2), 32'(m_rise));
        chk("fall2", 32'(fall2), 32'(m_fall));
        chk("cnt2",  32'(cnt2),  32'(m_cnt2));
        chk("excl",  32'(rise8 & fall8), 32'(0));
    endtask

    task automatic check_comb();
        bit exp_c;
        exp_c = !(a || b);
        chk("c8", 32'(c8), 32'(exp_c));
        chk("c2", 32'(c2), 32'(exp_c));
    endtask

    // one clock edge: model samples inputs at the edge, DUT checked 1ns later
    task automatic step();
        bit nc;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            nc     = !(a || b);
            m_rise = nc && !m_cq;
            m_fall = !nc && m_cq;
            if (nc != m_cq) begin
                m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end
            m_cq = nc;
        end
        #1;
        check_regs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a   = 1'b0;
        b   = 1'b0;
        repeat (3) step();
        check_comb();
        rst = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        model_reset();
        rst = 1'b1;
        a   = 1'b0;
        b   = 1'b0;
        #2;
        check_regs();

        // reset hold then release: first edge gives rise and count 1
        do_reset();
        step();
        step();

        // exhaustive truth table, combinational then registered
        for (int i = 0; i < 4; i++) begin
            {b, a} = 2'(i);
            #1;
            check_comb();
            step();
        end

        // alternating transitions from a fresh reset
        do_reset();
        step();
        for (int i = 0; i < 4; i++) begin
            a = ~a;
            step();
        end

        // X on one input is masked by a 1 on the other
        a = 1'b1;
        b = 1'bx;
        #1;
        chk("c8_x", 32'(c8), 32'(0));
        b = 1'b0;

        // steady toggling drives the narrow counter into saturation
        do_reset();
        for (int i = 0; i < 10; i++) begin
            a = ~a;
            step();
        end

        // random stimulus, with occasional glitches between edges
        for (int i = 0; i < 600; i++) begin
            a = 1'($urandom);
            b = 1'($urandom);
            #1;
            check_comb();
            if ($urandom_range(0, 7) == 0) begin
                a = ~a;
                #1;
                check_comb();
                a = ~a;
                #1;
                check_comb();
            end
            step();
        end

        // sub-cycle glitch from c=1 does not reach the registers
        a = 1'b0;
        b = 1'b0;
        step();
        a = 1'b1;
        #2;
        check_comb();
        a = 1'b0;
        #1;
        check_regs();
        step();

        // asynchronous reset between edges with count at 2
        do_reset();
        step();
        a = 1'b1;
        step();
        chk("cnt_pre", 32'(cnt8), 32'(2));
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_regs();
        check_comb();
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
